unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port and the MEM-stage data port (lw/sw).
- Sequences each memory transaction with a req/ack handshake and produces the stall signals that freeze the pipeline while either port waits.
- Data-port requests win by default, with an anti-starvation limit for fetch.
- The FlushFlag from the decode controller discards pending or in-flight fetches.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_DATA_RUN, 4, maximum consecutive data grants while if_req is pending; after that, fetch is granted once.
- TIMEOUT, 15, cycles waited for mem_ack after mem_req before aborting (4-bit counter minimum).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_done or flush
- if_addr  in  AW  fetch address (PC)
- if_rdata  out  DW  fetched instruction; valid when if_done=1
- if_done  out  1  one-cycle completion pulse, fetch port
- d_rd  in  1  data read (MemRead)
- d_wr  in  1  data write (MemWrite); d_rd and d_wr are never both 1
- d_addr  in  AW  data address (ALU result)
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid when d_done=1
- d_done  out  1  one-cycle completion pulse, data port
- flush  in  1  FlushFlag; kills the current fetch
- if_stall  out  1  if_req & ~if_done (combinational)
- d_stall  out  1  (d_rd|d_wr) & ~d_done (combinational)
- stall  out  1  if_stall | d_stall
- mem_req  out  1  memory request, registered
- mem_we  out  1  write enable, registered
- mem_addr  out  AW  registered address
- mem_wdata  out  DW  registered write data
- mem_rdata  in  DW  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- bus_err  out  1  sticky timeout flag

Behaviour:
Reset (async, rst_n=0):
- State=IDLE.
- mem_req, mem_we, if_done, d_done, bus_err = 0.
- mem_addr, mem_wdata, if_rdata, d_rdata = 0.
- Counters = 0, drop flag = 0.
- Reset asserted mid-transaction aborts it immediately. No done pulse follows.

FSM states: IDLE, FETCH, DATA.

IDLE grant decision (evaluated each cycle):
- dreq = (d_rd|d_wr) & ~d_done.
- ireq = if_req & ~if_done & ~flush.
- Go to DATA if dreq & (~ireq | run_cnt < MAX_DATA_RUN).
- Otherwise go to FETCH if ireq.
- Otherwise stay in IDLE.
- On grant, at the same edge: mem_req<=1; mem_addr, mem_we (=d_wr), and mem_wdata are loaded from the winning port; tmo_cnt<=0.
- A fetch grant always has mem_we=0.

Anti-starvation counter (run_cnt):
- DATA grant while if_req=1: run_cnt increments, saturating at MAX_DATA_RUN.
- FETCH grant, or if_req=0 in IDLE: run_cnt clears.

FETCH / DATA states:
- mem_req and all mem_* outputs are held stable until mem_ack.
- On mem_ack=1: next edge sets mem_req<=0, state<=IDLE, and latches mem_rdata into if_rdata (FETCH) or d_rdata (DATA, reads only).
- The matching done output is 1 for exactly the following cycle.
- Minimum latency: grant edge → mem_req high; ack in the same cycle → done high 2 cycles after the request was first seen.

Flush:
- flush=1 in IDLE: blocks a fetch grant that cycle.
- flush=1 at any cycle of FETCH: sets drop. The transaction still completes on mem_ack, but if_done is suppressed and if_rdata is not updated. Drop clears on return to IDLE.
- flush has no effect on DATA.

Timeout:
- tmo_cnt increments every cycle in FETCH or DATA without mem_ack.
- At tmo_cnt=TIMEOUT-1 with no ack: next edge sets mem_req<=0, state<=IDLE, bus_err<=1 (sticky until reset).
- The owning port's done pulses with rdata=0, so the pipeline never deadlocks. For a dropped fetch, the done is suppressed instead.

Back-to-back requests:
- A port's request is ineligible in its own done cycle, which prevents a duplicate grant while the requester updates its address.
- The other port may be granted in that same cycle.

mem_ack arriving while in IDLE is ignored.

Test Plan:
- Reset, then if_req=1, if_addr=0x40, mem_ack 3 cycles after mem_req, mem_rdata=0x2002000A → mem_addr=0x40, mem_we=0; if_done pulses once with if_rdata=0x2002000A; if_stall high until the done cycle.
- Same-cycle if_req (0x44) and d_wr (addr 0x100, wdata 0xDEADBEEF), immediate ack → DATA first (mem_we=1, addr 0x100), d_done; then FETCH of 0x44, if_done.
- Continuous d_rd plus if_req held, MAX_DATA_RUN=4 → exactly 4 data grants, then 1 fetch grant, then the data run restarts with run_cnt=0.
- Fetch of 0x48 granted, flush=1 for one cycle, ack after 2 cycles → no if_done, if_rdata unchanged, FSM in IDLE, next fetch granted normally.
- d_rd to 0x200 with mem_ack never asserted → mem_req drops after 15 cycles, bus_err=1 and stays set, d_done pulses with d_rdata=0.
- rst_n pulled low while in DATA with mem_req=1 → mem_req drops immediately (async), no d_done after release, FSM in IDLE.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbiter between the fetch port and the MEM-stage data port for one
// single-port unified memory. It owns the req/ack sequencing, fetch
// anti-starvation, flush-driven fetch dropping and the ack timeout.
module unified_mem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_DATA_RUN = 4,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    input  logic          flush,
    output logic          if_stall,
    output logic          d_stall,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          bus_err
);

    localparam int unsigned TW = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;
    localparam int unsigned RW = ($clog2(MAX_DATA_RUN + 1) > 1) ? $clog2(MAX_DATA_RUN + 1) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t          state, state_d;
    logic            mem_req_d, mem_we_d, if_done_d, d_done_d, bus_err_d;
    logic [AW-1:0]   mem_addr_d;
    logic [DW-1:0]   mem_wdata_d, if_rdata_d, d_rdata_d;
    logic [RW-1:0]   run_cnt, run_cnt_d;
    logic [TW-1:0]   tmo_cnt, tmo_cnt_d;
    logic            drop, drop_d;

    logic            dreq, ireq, grant_data, tmo_hit, fetch_kill, finish;

    // Request eligibility and grant decision; a port is ineligible in its own done cycle
    assign dreq       = (d_rd | d_wr) & ~d_done;
    assign ireq       = if_req & ~if_done & ~flush;
    assign grant_data = dreq & (~ireq | (run_cnt < RW'(MAX_DATA_RUN)));
    assign tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
    assign finish     = mem_ack | tmo_hit;
    assign fetch_kill = drop | flush;

    // Pipeline freeze signals
    assign if_stall = if_req & ~if_done;
    assign d_stall  = (d_rd | d_wr) & ~d_done;
    assign stall    = if_stall | d_stall;

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            bus_err   <= 1'b0;
            run_cnt   <= '0;
            tmo_cnt   <= '0;
            drop      <= 1'b0;
        end else begin
            state     <= state_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
            if_done   <= if_done_d;
            d_done    <= d_done_d;
            bus_err   <= bus_err_d;
            run_cnt   <= run_cnt_d;
            tmo_cnt   <= tmo_cnt_d;
            drop      <= drop_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        bus_err_d   = bus_err;
        run_cnt_d   = run_cnt;
        tmo_cnt_d   = tmo_cnt;
        drop_d      = drop;

        case (state)
            IDLE: begin
                drop_d = 1'b0;
                if (grant_data) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_wr;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    tmo_cnt_d   = '0;
                    if (if_req) begin
                        if (run_cnt < RW'(MAX_DATA_RUN)) begin
                            run_cnt_d = run_cnt + RW'(1);
                        end
                    end else begin
                        run_cnt_d = '0;
                    end
                end else if (ireq) begin
                    state_d     = FETCH;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    tmo_cnt_d   = '0;
                    run_cnt_d   = '0;
                end else if (!if_req) begin
                    run_cnt_d = '0;
                end
            end

            FETCH: begin
                drop_d = fetch_kill;
                if (finish) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    if (!mem_ack) begin
                        bus_err_d = 1'b1;
                    end
                    // A flushed fetch completes on the bus but is never delivered
                    if (!fetch_kill) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_ack ? mem_rdata : '0;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt + TW'(1);
                end
            end

            DATA: begin
                if (finish) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_done_d  = 1'b1;
                    if (!mem_ack) begin
                        bus_err_d = 1'b1;
                        d_rdata_d = '0;
                    end else if (!mem_we) begin
                        d_rdata_d = mem_rdata;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt + TW'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed stimulus pushes expected
// grants and completions; a negedge monitor pops and compares them.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_rd, d_wr;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_done;
    logic        flush, flush_r, tie_flush;
    logic        if_stall, d_stall, stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    assign flush = flush_r | (tie_flush & d_done);

    unified_mem_arbiter #(.AW(32), .DW(32), .MAX_DATA_RUN(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .flush(flush),
        .if_stall(if_stall), .d_stall(d_stall), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        chk_wdata;
    } grant_t;

    grant_t      gq[$];
    logic [31:0] ifq[$];
    logic [31:0] dq[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_grant(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic cw);
        grant_t g;
        g.addr = a; g.we = we; g.wdata = wd; g.chk_wdata = cw;
        gq.push_back(g);
    endtask

    function automatic logic [31:0] model(input logic [31:0] a);
        return (a == 32'h40) ? 32'h2002000A : {16'hC0DE, a[15:0]};
    endfunction

    // Memory responder: acks after ack_delay cycles of mem_req (never if negative)
    int ack_delay = 0;
    int rcnt = 0;
    always @(negedge clk) begin
        if (!mem_req) begin
            rcnt      = 0;
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0BAD0;
        end else begin
            mem_ack   = (ack_delay >= 0) && (rcnt == ack_delay);
            mem_rdata = mem_ack ? model(mem_addr) : 32'hBAD0BAD0;
            rcnt++;
        end
    end

    // Monitor: compare each new grant and each done pulse against the queues
    logic   prev_req = 1'b0;
    grant_t mg;
    always @(negedge clk) begin
        if (mem_req && !prev_req) begin
            if (gq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_grant: addr %h we %b, expected no grant", mem_addr, mem_we);
            end else begin
                mg = gq.pop_front();
                check("grant_addr", mem_addr, mg.addr);
                check("grant_we", 32'(mem_we), 32'(mg.we));
                if (mg.chk_wdata) check("grant_wdata", mem_wdata, mg.wdata);
            end
        end
        prev_req = mem_req;
        if (if_done) begin
            if (ifq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_if_done: rdata %h, expected no pulse", if_rdata);
            end else begin
                check("if_rdata", if_rdata, ifq.pop_front());
            end
        end
        if (d_done) begin
            if (dq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_d_done: rdata %h, expected no pulse", d_rdata);
            end else begin
                check("d_rdata", d_rdata, dq.pop_front());
            end
        end
    end

    // Hold requests until their done pulses, with a cycle budget
    task automatic serve(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (if_done) if_req = 1'b0;
            if (d_done) begin d_rd = 1'b0; d_wr = 1'b0; end
            if (!if_req && !d_rd && !d_wr) return;
        end
        n_cmp++; n_err++;
        $display("FAIL %s_timeout: requests still pending, expected completion within %0d cycles", name, max_cyc);
        if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_if, req_cycles;
        bit  seen, reasserted, stall_ok;

        rst_n = 1'b1; if_req = 1'b0; if_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
        d_addr = '0; d_wdata = '0; flush_r = 1'b0; tie_flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_done", 32'(if_done), 0);
        check("rst_d_done", 32'(d_done), 0);
        check("rst_bus_err", 32'(bus_err), 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_stall", 32'(stall), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fetch 0x40 acked three cycles after the request rises
        ack_delay = 3;
        if_req = 1'b1; if_addr = 32'h40;
        push_grant(32'h40, 1'b0, 32'h0, 1'b0);
        ifq.push_back(32'h2002000A);
        #1;
        check("t1_if_stall", 32'(if_stall), 1);
        check("t1_stall", 32'(stall), 1);
        check("t1_d_stall", 32'(d_stall), 0);
        seen = 1'b0; stall_ok = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (if_done) begin
                check("t1_if_stall_done", 32'(if_stall), 0);
                if_req = 1'b0; seen = 1'b1;
            end else if (!if_stall) begin
                stall_ok = 1'b0;
            end
        end
        check("t1_if_done_seen", 32'(seen), 1);
        check("t1_stall_held", 32'(stall_ok), 1);
        repeat (2) @(negedge clk);

        // Simultaneous store and fetch: data first, then fetch
        ack_delay = 0;
        if_req = 1'b1; if_addr = 32'h44;
        d_wr = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        push_grant(32'h100, 1'b1, 32'hDEADBEEF, 1'b1);
        push_grant(32'h44, 1'b0, 32'h0, 1'b0);
        dq.push_back(32'h0);
        ifq.push_back(32'hC0DE0044);
        #1;
        check("t2_d_stall", 32'(d_stall), 1);
        serve("t2", 30);
        repeat (2) @(negedge clk);

        // Anti-starvation: flush tied to d_done keeps fetch out of done cycles
        tie_flush = 1'b1;
        d_rd = 1'b1; d_addr = 32'h300;
        if_req = 1'b1; if_addr = 32'h4C;
        for (int k = 0; k < 4; k++) push_grant(32'h300, 1'b0, 32'h0, 1'b0);
        push_grant(32'h4C, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 5; k++) push_grant(32'h300, 1'b0, 32'h0, 1'b0);
        push_grant(32'h50, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 9; k++) dq.push_back(32'hC0DE0300);
        ifq.push_back(32'hC0DE004C);
        ifq.push_back(32'hC0DE0050);
        n_if = 0; reasserted = 1'b0;
        for (int i = 0; i < 200 && n_if < 2; i++) begin
            @(negedge clk);
            if (if_done) begin
                n_if++;
                if_req = 1'b0;
                if (n_if == 2) d_rd = 1'b0;
            end else if (n_if == 1 && !reasserted) begin
                if_req = 1'b1; if_addr = 32'h50; reasserted = 1'b1;
            end
        end
        check("t3_fetch_count", 32'(n_if), 2);
        tie_flush = 1'b0; if_req = 1'b0; d_rd = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_grants_left", 32'(gq.size()), 0);

        // Flushed fetch of 0x48 completes silently; next fetch works
        ack_delay = 2;
        if_req = 1'b1; if_addr = 32'h48;
        push_grant(32'h48, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("t4_granted", 32'(mem_req), 1);
        flush_r = 1'b1; if_req = 1'b0;
        @(negedge clk);
        flush_r = 1'b0;
        repeat (5) @(negedge clk);
        check("t4_if_rdata_kept", if_rdata, 32'hC0DE0050);
        check("t4_mem_req_idle", 32'(mem_req), 0);
        ack_delay = 0;
        if_req = 1'b1; if_addr = 32'h60;
        push_grant(32'h60, 1'b0, 32'h0, 1'b0);
        ifq.push_back(32'hC0DE0060);
        serve("t4", 20);
        repeat (2) @(negedge clk);

        // Load of 0x200 never acked: timeout after 15 request cycles
        ack_delay = -1;
        d_rd = 1'b1; d_addr = 32'h200;
        push_grant(32'h200, 1'b0, 32'h0, 1'b0);
        dq.push_back(32'h0);
        req_cycles = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_req) req_cycles++;
            if (d_done) begin d_rd = 1'b0; seen = 1'b1; end
        end
        check("t5_d_done_seen", 32'(seen), 1);
        check("t5_req_cycles", 32'(req_cycles), 15);
        check("t5_bus_err", 32'(bus_err), 1);
        repeat (5) @(negedge clk);
        check("t5_bus_err_sticky", 32'(bus_err), 1);

        // Reset in the middle of a data transaction
        d_rd = 1'b1; d_addr = 32'h210;
        push_grant(32'h210, 1'b0, 32'h0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (mem_req) seen = 1'b1;
        end
        check("t6_req_seen", 32'(seen), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0; d_rd = 1'b0;
        #1;
        check("t6_mem_req_async", 32'(mem_req), 0);
        check("t6_bus_err_cleared", 32'(bus_err), 0);
        check("t6_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("t6_mem_req_after", 32'(mem_req), 0);
        check("t6_d_rdata", d_rdata, 0);

        check("end_grant_queue", 32'(gq.size()), 0);
        check("end_if_queue", 32'(ifq.size()), 0);
        check("end_d_queue", 32'(dq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
